dose_schedule_ctrl: RTL and testbench

DOSE_SCHEDULE_CTRL -- requirements
Module: dose_schedule_ctrl

---
 rtl/dose_schedule_ctrl.sv | 139 +++++++++++++
 tb/tb_dose_schedule_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dose_schedule_ctrl.sv
// Dose reminder sequencer: walks a schedule ROM of tick intervals, raises Alarm
// when each interval elapses, and counts doses that go unacknowledged.
module dose_schedule_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int NUM_ENTRIES = 16,
  parameter int TIMEOUT     = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tick,
  input  logic              Ack,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [DATA_W-1:0] RomData,
  output logic              Alarm,
  output logic [ADDR_W-1:0] DoseIdx,
  output logic              Missed,
  output logic [3:0]        MissCnt,
  output logic              Halted
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    LOAD  = 3'd1,
    COUNT = 3'd2,
    ALERT = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] CD_ONE   = DATA_W'(1);
  localparam logic [7:0]        TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0]        TO_ONE   = 8'd1;
  localparam logic [3:0]        MISS_ONE = 4'd1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d, index_inc;
  logic [DATA_W-1:0] countdown_q, countdown_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic [3:0]        miss_cnt_q, miss_cnt_d;
  logic              alarm_q, alarm_d;
  logic              missed_q, missed_d;
  logic              halted_q, halted_d;
  logic              miss_event;

  // Wrap at the last entry without needing an end-of-list marker there.
  assign index_inc = (index_q == LAST_IDX) ? '0 : index_q + IDX_ONE;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= FETCH;
      index_q     <= '0;
      countdown_q <= '0;
      tcnt_q      <= '0;
      miss_cnt_q  <= '0;
      alarm_q     <= 1'b0;
      missed_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      countdown_q <= countdown_d;
      tcnt_q      <= tcnt_d;
      miss_cnt_q  <= miss_cnt_d;
      alarm_q     <= alarm_d;
      missed_q    <= missed_d;
      halted_q    <= halted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    countdown_d = countdown_q;
    tcnt_d      = tcnt_q;
    miss_cnt_d  = miss_cnt_q;
    miss_event  = 1'b0;
    case (state_q)
      FETCH: state_d = LOAD;
      LOAD: begin
        if (RomData != '0) begin
          countdown_d = RomData;
          state_d     = COUNT;
        end else if (index_q == '0) begin
          state_d = HALT;
        end else begin
          index_d = '0;
          state_d = FETCH;
        end
      end
      COUNT: begin
        if (Tick) begin
          countdown_d = countdown_q - CD_ONE;
          if (countdown_q == CD_ONE) begin
            tcnt_d  = '0;
            state_d = ALERT;
          end
        end
      end
      ALERT: begin
        // Ack wins over a timeout-reaching tick in the same cycle.
        if (Ack) begin
          tcnt_d  = '0;
          index_d = index_inc;
          state_d = FETCH;
        end else if (Tick) begin
          if (tcnt_q == TO_LAST) begin
            miss_event = 1'b1;
            tcnt_d     = '0;
            index_d    = index_inc;
            state_d    = FETCH;
            if (miss_cnt_q != 4'hF) begin
              miss_cnt_d = miss_cnt_q + MISS_ONE;
            end
          end else begin
            tcnt_d = tcnt_q + TO_ONE;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    alarm_d  = (state_d == ALERT);
    halted_d = (state_d == HALT);
    missed_d = miss_event;
  end

  assign RomAddr = index_q;
  assign DoseIdx = index_q;
  assign Alarm   = alarm_q;
  assign Missed  = missed_q;
  assign MissCnt = miss_cnt_q;
  assign Halted  = halted_q;

endmodule

// File: tb/tb_dose_schedule_ctrl.sv
// Bench for dose_schedule_ctrl: a procedural dose-timeline model runs beside the
// DUT and is compared every cycle; directed scenarios add hand-computed checks.
`timescale 1ns/1ps
module tb_dose_schedule_ctrl;
  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 4;
  localparam int NUM_ENTRIES = 16;
  localparam int TIMEOUT     = 8;

  logic              Clk;
  logic              Rst = 1'b0;
  logic              Tick = 1'b0;
  logic              Ack = 1'b0;
  logic [ADDR_W-1:0] RomAddr;
  logic [DATA_W-1:0] RomData;
  logic              Alarm;
  logic [ADDR_W-1:0] DoseIdx;
  logic              Missed;
  logic [3:0]        MissCnt;
  logic              Halted;

  logic [DATA_W-1:0] rom [NUM_ENTRIES];

  int total = 0;
  int bad   = 0;

  // model state
  int m_idx, m_misscnt;
  bit m_alarm, m_missed, m_halted, m_abort;

  dose_schedule_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_ENTRIES(NUM_ENTRIES), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .Ack(Ack),
    .RomAddr(RomAddr), .RomData(RomData),
    .Alarm(Alarm), .DoseIdx(DoseIdx), .Missed(Missed),
    .MissCnt(MissCnt), .Halted(Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) RomData <= rom[RomAddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic m_clear();
    m_idx = 0; m_misscnt = 0; m_alarm = 0; m_missed = 0; m_halted = 0;
  endtask

  task automatic m_step();
    @(posedge Clk or negedge Rst);
    if (Rst !== 1'b1) m_abort = 1;
    else m_missed = 0;
  endtask

  task automatic m_run();
    int val, left, waited;
    bit missed_now;
    forever begin
      m_step(); if (m_abort) return;   // address presented
      m_step(); if (m_abort) return;   // word examined
      val = int'(rom[m_idx]);
      if (val == 0) begin
        if (m_idx == 0) begin
          m_halted = 1;
          $display("txn halt: schedule empty");
          forever begin m_step(); if (m_abort) return; end
        end
        m_idx = 0;
        continue;
      end
      left = val;
      while (left > 0) begin
        m_step(); if (m_abort) return;
        if (Tick) left--;
      end
      m_alarm = 1;
      waited = 0;
      missed_now = 0;
      forever begin
        m_step(); if (m_abort) return;
        if (Ack) break;
        if (Tick) begin
          waited++;
          if (waited == TIMEOUT) begin
            missed_now = 1;
            m_missed = 1;
            m_misscnt = (m_misscnt < 15) ? m_misscnt + 1 : 15;
            break;
          end
        end
      end
      m_alarm = 0;
      $display("txn dose idx=%0d interval=%0d result=%s misscnt=%0d",
               m_idx, val, missed_now ? "missed" : "acked", m_misscnt);
      m_idx = (m_idx + 1) % NUM_ENTRIES;
    end
  endtask

  initial begin
    forever begin
      m_clear();
      m_abort = 0;
      wait (Rst === 1'b1);
      m_run();
    end
  end

  // one compare process, every cycle
  always @(negedge Clk) begin
    chk("alarm",   32'(Alarm),   32'(m_alarm));
    chk("doseidx", 32'(DoseIdx), 32'(m_idx));
    chk("romaddr", 32'(RomAddr), 32'(m_idx));
    chk("missed",  32'(Missed),  32'(m_missed));
    chk("misscnt", 32'(MissCnt), 32'(m_misscnt));
    chk("halted",  32'(Halted),  32'(m_halted));
  end

  // ---------------- stimulus helpers ----------------
  task automatic begin_reset();
    @(negedge Clk);
    #2;
    Rst = 1'b0; Tick = 1'b0; Ack = 1'b0;
  endtask

  task automatic end_reset();
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic fill_rom(input int v);
    for (int e = 0; e < NUM_ENTRIES; e++) rom[e] = DATA_W'(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rises[$];
    int rise_t[$];
    bit prev, seen;
    int aticks, first_aticks, pulses, acks_done, pend, exp_idx, found;

    fill_rom(0);

    // ---- empty schedule halts two cycles after release ----
    begin_reset();
    #1;
    chk("rst_alarm",   32'(Alarm), 0);
    chk("rst_doseidx", 32'(DoseIdx), 0);
    chk("rst_misscnt", 32'(MissCnt), 0);
    chk("rst_halted",  32'(Halted), 0);
    end_reset();
    @(negedge Clk);
    chk("halt_1cyc", 32'(Halted), 0);
    @(negedge Clk);
    chk("halt_2cyc", 32'(Halted), 1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (Alarm) seen = 1;
      Tick = 1'($urandom_range(0, 1));
      Ack  = 1'($urandom_range(0, 1));
    end
    chk("halt_no_alarm", 32'(seen), 0);
    chk("halt_held", 32'(Halted), 1);

    // ---- {3,2,0}: tick every 4 cycles, ack held ----
    begin_reset();
    fill_rom(0); rom[0] = 4'd3; rom[1] = 4'd2;
    end_reset();
    prev = 0;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) @(negedge Clk);
      if (Alarm && !prev) begin rises.push_back(int'(DoseIdx)); rise_t.push_back(i); end
      prev = Alarm;
      Tick = (i % 4 == 0);
      Ack  = 1'b1;
    end
    chk("seq_nrises", 32'(rises.size() >= 4), 1);
    if (rises.size() >= 4) begin
      chk("seq_idx0", 32'(rises[0]), 0);
      chk("seq_idx1", 32'(rises[1]), 1);
      chk("seq_idx2", 32'(rises[2]), 0);
      chk("seq_idx3", 32'(rises[3]), 1);
      chk("seq_t0", 32'(rise_t[0]), 13);
      chk("seq_t1", 32'(rise_t[1]), 21);
      chk("seq_t2", 32'(rise_t[2]), 37);
    end

    // ---- all ones, never ack: timeouts and saturation ----
    begin_reset();
    fill_rom(1);
    end_reset();
    prev = 0; aticks = 0; first_aticks = -1; pulses = 0;
    for (int i = 0; i < 500; i++) begin
      if (i > 0) @(negedge Clk);
      if (prev && !Alarm && first_aticks < 0) first_aticks = aticks;
      if (!Alarm) aticks = 0;
      if (Missed) begin
        pulses++;
        if (pulses == 1) begin
          chk("miss1_cnt", 32'(MissCnt), 1);
          chk("miss1_idx", 32'(DoseIdx), 1);
        end
      end
      prev = Alarm;
      Tick = (i % 2 == 0);
      Ack  = 1'b0;
      if (Alarm && Tick) aticks++;
    end
    chk("alarm_ticks", 32'(first_aticks), TIMEOUT);
    chk("miss_ge16", 32'(pulses >= 16), 1);
    chk("miss_sat", 32'(MissCnt), 15);

    // ---- ack on the same tick that would time out ----
    begin_reset();
    fill_rom(1);
    end_reset();
    aticks = 0; acks_done = 0; pend = 0; exp_idx = 0;
    for (int i = 0; i < 150; i++) begin
      if (i > 0) @(negedge Clk);
      if (pend) begin
        chk("tie_missed",  32'(Missed), 0);
        chk("tie_alarm",   32'(Alarm), 0);
        chk("tie_misscnt", 32'(MissCnt), 0);
        if (acks_done <= 3) chk("tie_idx", 32'(DoseIdx), 32'(exp_idx));
        pend = 0;
      end
      if (!Alarm) aticks = 0;
      Tick = (i % 2 == 0);
      Ack  = Alarm && Tick && (aticks == TIMEOUT - 1);
      if (Alarm && Tick) aticks++;
      if (Ack) begin pend = 1; acks_done++; exp_idx = acks_done; end
    end
    chk("tie_count", 32'(acks_done >= 3), 1);

    // ---- 16 entries of 1, always ack: no stall at wrap ----
    begin_reset();
    fill_rom(1);
    end_reset();
    rises.delete(); rise_t.delete(); prev = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge Clk);
      if (Alarm && !prev) begin rises.push_back(int'(DoseIdx)); rise_t.push_back(i); end
      prev = Alarm;
      Tick = 1'b1; Ack = 1'b1;
    end
    chk("wrap_nrises", 32'(rises.size() >= 18), 1);
    if (rises.size() >= 18) begin
      for (int k = 0; k < 18; k++) chk("wrap_idx", 32'(rises[k]), 32'(k % 16));
      chk("wrap_first", 32'(rise_t[0]), 3);
      for (int k = 1; k < 18; k++) chk("wrap_gap", 32'(rise_t[k] - rise_t[k-1]), 4);
    end

    // ---- async reset while alarming at index 5 ----
    begin_reset();
    fill_rom(1);
    end_reset();
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (i > 0) @(negedge Clk);
      if (Alarm && DoseIdx == 5) found = 1;
      else begin
        Tick = 1'($urandom_range(0, 1));
        Ack  = (DoseIdx != 5);
      end
    end
    chk("reach_idx5", 32'(found), 1);
    #2;
    Rst = 1'b0; Tick = 1'b0; Ack = 1'b0;
    #1;
    chk("ar_alarm",   32'(Alarm), 0);
    chk("ar_doseidx", 32'(DoseIdx), 0);
    chk("ar_romaddr", 32'(RomAddr), 0);
    chk("ar_missed",  32'(Missed), 0);
    chk("ar_misscnt", 32'(MissCnt), 0);
    chk("ar_halted",  32'(Halted), 0);
    end_reset();
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (Missed) seen = 1;
    end
    chk("ar_no_miss", 32'(seen), 0);
    chk("ar_restart", 32'(DoseIdx), 0);

    // ---- randomized schedules against the model ----
    for (int r = 0; r < 8; r++) begin
      int tp, ap;
      begin_reset();
      for (int e = 0; e < NUM_ENTRIES; e++)
        rom[e] = ($urandom_range(0, 9) < 2) ? '0 : DATA_W'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) rom[0] = '0;
      tp = $urandom_range(0, 4);
      ap = $urandom_range(0, 12);
      end_reset();
      for (int i = 0; i < 400; i++) begin
        @(negedge Clk);
        Tick = ($urandom_range(0, tp) == 0);
        Ack  = (ap == 12) ? 1'b0 : ($urandom_range(0, ap) == 0);
      end
    end

    @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
